// File: rtl/beep_pkg.sv
// Shared definitions for the beep scheduler: state and source encodings,
// default timing constants and small helper functions.
package beep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLICK,
    ST_CHIME_ON,
    ST_CHIME_OFF,
    ST_ALARM_ON,
    ST_ALARM_OFF
  } beep_state_t;

  localparam logic [1:0] SRC_NONE  = 2'b00;
  localparam logic [1:0] SRC_CLICK = 2'b01;
  localparam logic [1:0] SRC_CHIME = 2'b10;
  localparam logic [1:0] SRC_ALARM = 2'b11;

  localparam int unsigned DEF_CLICK_CYC     = 5_000_000;
  localparam int unsigned DEF_CHIME_ON_CYC  = 20_000_000;
  localparam int unsigned DEF_CHIME_OFF_CYC = 30_000_000;
  localparam int unsigned DEF_ALARM_SECS    = 60;
  localparam int unsigned DEF_SNOOZE_MIN    = 5;

  localparam int unsigned TIMER_W = 32;
  localparam int unsigned ALARM_W = 16;

  // Number of chime beeps for an hour value: hours mod 12, with 0 shown as 12.
  function automatic logic [3:0] chime_count(input logic [5:0] h);
    logic [5:0] r;
    r = h % 6'd12;
    return (r == 6'd0) ? 4'd12 : r[3:0];
  endfunction

  // {hours, minutes} of now + add minutes; minutes wrap at 60 with carry, hours wrap at 24.
  // add is expected to be below 60.
  function automatic logic [11:0] snooze_target(input logic [5:0] h, input logic [5:0] m,
                                                input int unsigned add);
    logic [6:0] ms;
    logic [5:0] hs;
    ms = {1'b0, m} + 7'(add);
    hs = h;
    if (ms >= 7'd60) begin
      ms = ms - 7'd60;
      hs = (h >= 6'd23) ? 6'd0 : h + 6'd1;
    end
    return {hs, ms[5:0]};
  endfunction

endpackage

// File: rtl/beep_phase_timer.sv
// Loadable down-counter used for click and chime on/off phases.
// done is high while the count sits at zero; the count saturates there.
module beep_phase_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  // Count down to zero after each load, holding at zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/beep_scheduler.sv
// Arbitrates the audio_player beep gate between alarm, hourly chime and key
// click with fixed priority alarm > chime > click.
// Optional snooze support is built when BEEP_SNOOZE_EN is defined.
module beep_scheduler
  import beep_pkg::*;
#(
  parameter int unsigned CLICK_CYC     = DEF_CLICK_CYC,
  parameter int unsigned CHIME_ON_CYC  = DEF_CHIME_ON_CYC,
  parameter int unsigned CHIME_OFF_CYC = DEF_CHIME_OFF_CYC,
  parameter int unsigned ALARM_SECS    = DEF_ALARM_SECS,
  parameter int unsigned SNOOZE_MIN    = DEF_SNOOZE_MIN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_1hz,
  input  logic [5:0] hours,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic [5:0] alarm_hours,
  input  logic [5:0] alarm_minutes,
  input  logic       alarm_en,
  input  logic       set_mod,
  input  logic       key_press,
  input  logic       stop,
  input  logic       snooze,
  output logic       beep_en,
  output logic [1:0] source,
  output logic       alarm_ringing
);

  beep_state_t        state, state_nxt;
  logic [ALARM_W-1:0] alarm_left, alarm_left_nxt;
  logic [3:0]         beeps_left, beeps_left_nxt;
  logic               timer_load;
  logic [TIMER_W-1:0] timer_val;
  logic               timer_done;
  logic               beep_en_nxt;
  logic [1:0]         source_nxt;
  logic               ringing_nxt;

  logic trig_ok, in_alarm, alarm_match, chime_hit, alarm_fire;
  logic snooze_match, snooze_take;

  assign trig_ok     = tick_1hz & ~set_mod;
  assign in_alarm    = (state == ST_ALARM_ON) || (state == ST_ALARM_OFF);
  assign alarm_match = alarm_en && (hours == alarm_hours) && (minutes == alarm_minutes)
                       && (seconds == 6'd0);
  assign chime_hit   = trig_ok && (minutes == 6'd0) && (seconds == 6'd0);
  assign alarm_fire  = trig_ok && (alarm_match || snooze_match);

`ifdef BEEP_SNOOZE_EN
  logic       snz_armed;
  logic [5:0] snz_hours, snz_minutes;

  assign snooze_take  = snooze && in_alarm;
  assign snooze_match = snz_armed && (hours == snz_hours) && (minutes == snz_minutes)
                        && (seconds == 6'd0);

  // Snooze target register: armed by snooze while ringing, cleared by stop or alarm disable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snz_armed   <= 1'b0;
      snz_hours   <= '0;
      snz_minutes <= '0;
    end else if (stop || !alarm_en) begin
      snz_armed <= 1'b0;
    end else if (snooze_take) begin
      snz_armed                  <= 1'b1;
      {snz_hours, snz_minutes}   <= snooze_target(hours, minutes, SNOOZE_MIN);
    end
  end
`else
  logic unused_snooze;
  assign unused_snooze = snooze;
  assign snooze_take   = 1'b0;
  assign snooze_match  = 1'b0;
`endif

  beep_phase_timer #(
    .W(TIMER_W)
  ) u_phase_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Next-state, pattern counters and registered-output decode.
  always_comb begin
    state_nxt      = state;
    alarm_left_nxt = alarm_left;
    beeps_left_nxt = beeps_left;
    timer_load     = 1'b0;
    timer_val      = '0;

    if (stop || snooze_take) begin
      state_nxt = ST_IDLE;
    end else if (alarm_fire && !in_alarm) begin
      state_nxt      = ST_ALARM_ON;
      alarm_left_nxt = ALARM_W'(ALARM_SECS);
    end else if (chime_hit && ((state == ST_IDLE) || (state == ST_CLICK))) begin
      state_nxt      = ST_CHIME_ON;
      beeps_left_nxt = chime_count(hours);
      timer_load     = 1'b1;
      timer_val      = TIMER_W'(CHIME_ON_CYC - 1);
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (key_press) begin
            state_nxt  = ST_CLICK;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(CLICK_CYC - 1);
          end
        end
        ST_CLICK: begin
          if (key_press) begin
            timer_load = 1'b1;
            timer_val  = TIMER_W'(CLICK_CYC - 1);
          end else if (timer_done) begin
            state_nxt = ST_IDLE;
          end
        end
        ST_CHIME_ON: begin
          if (timer_done) begin
            if (beeps_left <= 4'd1) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt      = ST_CHIME_OFF;
              beeps_left_nxt = beeps_left - 4'd1;
              timer_load     = 1'b1;
              timer_val      = TIMER_W'(CHIME_OFF_CYC - 1);
            end
          end
        end
        ST_CHIME_OFF: begin
          if (timer_done) begin
            state_nxt  = ST_CHIME_ON;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(CHIME_ON_CYC - 1);
          end
        end
        ST_ALARM_ON, ST_ALARM_OFF: begin
          if (tick_1hz) begin
            if (alarm_left <= ALARM_W'(1)) begin
              state_nxt      = ST_IDLE;
              alarm_left_nxt = '0;
            end else begin
              state_nxt      = (state == ST_ALARM_ON) ? ST_ALARM_OFF : ST_ALARM_ON;
              alarm_left_nxt = alarm_left - 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end

    beep_en_nxt = 1'b0;
    source_nxt  = SRC_NONE;
    ringing_nxt = 1'b0;
    unique case (state_nxt)
      ST_CLICK:     begin beep_en_nxt = 1'b1; source_nxt = SRC_CLICK; end
      ST_CHIME_ON:  begin beep_en_nxt = 1'b1; source_nxt = SRC_CHIME; end
      ST_CHIME_OFF: begin                     source_nxt = SRC_CHIME; end
      ST_ALARM_ON:  begin beep_en_nxt = 1'b1; source_nxt = SRC_ALARM; ringing_nxt = 1'b1; end
      ST_ALARM_OFF: begin                     source_nxt = SRC_ALARM; ringing_nxt = 1'b1; end
      default:      begin end
    endcase
  end

  // State, counters and outputs register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      alarm_left    <= '0;
      beeps_left    <= '0;
      beep_en       <= 1'b0;
      source        <= SRC_NONE;
      alarm_ringing <= 1'b0;
    end else begin
      state         <= state_nxt;
      alarm_left    <= alarm_left_nxt;
      beeps_left    <= beeps_left_nxt;
      beep_en       <= beep_en_nxt;
      source        <= source_nxt;
      alarm_ringing <= ringing_nxt;
    end
  end

endmodule

// File: tb/tb_beep_scheduler.sv
// Directed testbench for beep_scheduler with short phase lengths.
// Snooze expectations follow BEEP_SNOOZE_EN.
module tb_beep_scheduler;

  logic       clk;
  logic       reset_n;
  logic       tick_1hz;
  logic [5:0] hours, minutes, seconds;
  logic [5:0] alarm_hours, alarm_minutes;
  logic       alarm_en, set_mod, key_press, stop, snooze;
  logic       beep_en;
  logic [1:0] source;
  logic       alarm_ringing;

  int n_checks = 0;
  int n_fail   = 0;

  beep_scheduler #(
    .CLICK_CYC     (4),
    .CHIME_ON_CYC  (3),
    .CHIME_OFF_CYC (2),
    .ALARM_SECS    (4),
    .SNOOZE_MIN    (5)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_1hz      (tick_1hz),
    .hours         (hours),
    .minutes       (minutes),
    .seconds       (seconds),
    .alarm_hours   (alarm_hours),
    .alarm_minutes (alarm_minutes),
    .alarm_en      (alarm_en),
    .set_mod       (set_mod),
    .key_press     (key_press),
    .stop          (stop),
    .snooze        (snooze),
    .beep_en       (beep_en),
    .source        (source),
    .alarm_ringing (alarm_ringing)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic b, input logic [1:0] src, input logic ring);
    check({tag, "_beep"}, 32'(beep_en), 32'(b));
    check({tag, "_src"}, 32'(source), 32'(src));
    check({tag, "_ring"}, 32'(alarm_ringing), 32'(ring));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_at(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    hours = h; minutes = m; seconds = s;
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  task automatic press_key();
    key_press = 1'b1;
    step();
    key_press = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Chime of n beeps: ON 3 cycles, OFF 2 cycles, no trailing OFF; key pulse at cycle kp (-1 none).
  task automatic run_chime(input string tag, input int n, input int kp);
    int len;
    len = 5 * n - 2;
    for (int k = 0; k <= len; k++) begin
      check_out($sformatf("%s[%0d]", tag, k), (k < len) && ((k % 5) < 3),
                (k < len) ? 2'b10 : 2'b00, 1'b0);
      if (k == kp) key_press = 1'b1;
      step();
      key_press = 1'b0;
    end
  endtask

  initial begin
    reset_n = 1'b0; tick_1hz = 1'b0;
    hours = '0; minutes = 6'd30; seconds = 6'd15;
    alarm_hours = '0; alarm_minutes = '0;
    alarm_en = 1'b0; set_mod = 1'b0; key_press = 1'b0; stop = 1'b0; snooze = 1'b0;
    step(); step();
    check_out("reset", 1'b0, 2'b00, 1'b0);
    reset_n = 1'b1;
    step();

    // single click: 4 beep cycles then idle
    press_key();
    for (int k = 0; k <= 4; k++) begin
      check_out($sformatf("click[%0d]", k), k < 4, (k < 4) ? 2'b01 : 2'b00, 1'b0);
      step();
    end

    // click restarted by a second press at cycle 1: beep through cycle 5
    press_key();
    for (int k = 0; k <= 6; k++) begin
      check_out($sformatf("restart[%0d]", k), k < 6, (k < 6) ? 2'b01 : 2'b00, 1'b0);
      if (k == 1) key_press = 1'b1;
      step();
      key_press = 1'b0;
    end

    // 15:00:00 chime, with a key press during the OFF gap that must be ignored
    tick_at(6'd15, 6'd0, 6'd0);
    run_chime("chime15", 3, 4);
    // midnight chime: 12 beeps
    tick_at(6'd0, 6'd0, 6'd0);
    run_chime("chime00", 12, -1);

    // alarm at 07:00 beats chime; toggles on ticks, idle after 4 ticks
    alarm_hours = 6'd7; alarm_minutes = 6'd0; alarm_en = 1'b1;
    tick_at(6'd7, 6'd0, 6'd0);
    check_out("alarm_t0", 1'b1, 2'b11, 1'b1);
    step(); step();
    check_out("alarm_hold", 1'b1, 2'b11, 1'b1);
    tick_at(6'd7, 6'd0, 6'd1);
    check_out("alarm_t1", 1'b0, 2'b11, 1'b1);
    tick_at(6'd7, 6'd0, 6'd2);
    check_out("alarm_t2", 1'b1, 2'b11, 1'b1);
    tick_at(6'd7, 6'd0, 6'd3);
    check_out("alarm_t3", 1'b0, 2'b11, 1'b1);
    tick_at(6'd7, 6'd0, 6'd4);
    check_out("alarm_end", 1'b0, 2'b00, 1'b0);
    step(); step();
    check_out("alarm_after", 1'b0, 2'b00, 1'b0);

    // alarm preempts a running click; stop silences it next cycle
    alarm_hours = 6'd9; alarm_minutes = 6'd30;
    press_key();
    check_out("pre_click", 1'b1, 2'b01, 1'b0);
    step();
    tick_at(6'd9, 6'd30, 6'd0);
    check_out("pre_alarm", 1'b1, 2'b11, 1'b1);
    press_stop();
    check_out("stop_alarm", 1'b0, 2'b00, 1'b0);

    // chime preempts a click
    press_key();
    tick_at(6'd10, 6'd0, 6'd0);
    check_out("chime_over_click", 1'b1, 2'b10, 1'b0);
    press_stop();
    check_out("stop_chime", 1'b0, 2'b00, 1'b0);

    // stop wins over a same-cycle chime trigger
    stop = 1'b1;
    tick_at(6'd11, 6'd0, 6'd0);
    stop = 1'b0;
    check_out("stop_wins", 1'b0, 2'b00, 1'b0);

    // set_mod suppresses alarm and chime but not clicks
    alarm_hours = 6'd8; alarm_minutes = 6'd0; set_mod = 1'b1;
    tick_at(6'd8, 6'd0, 6'd0);
    check_out("setmod_tick", 1'b0, 2'b00, 1'b0);
    press_key();
    check_out("setmod_click", 1'b1, 2'b01, 1'b0);
    set_mod = 1'b0;
    press_stop();

    // asynchronous reset mid-click; nothing resumes after release
    press_key();
    check_out("rst_pre", 1'b1, 2'b01, 1'b0);
    #1 reset_n = 1'b0;
    #1 check_out("rst_async", 1'b0, 2'b00, 1'b0);
    step();
    reset_n = 1'b1;
    step(); step();
    check_out("rst_after", 1'b0, 2'b00, 1'b0);

    // snooze at 23:58 re-rings at 00:03:00 only with snooze support built in
    alarm_hours = 6'd23; alarm_minutes = 6'd58; alarm_en = 1'b1;
    tick_at(6'd23, 6'd58, 6'd0);
    check_out("snz_ring", 1'b1, 2'b11, 1'b1);
    seconds = 6'd30;
    step();
    snooze = 1'b1;
    step();
    snooze = 1'b0;
`ifdef BEEP_SNOOZE_EN
    check_out("snz_take", 1'b0, 2'b00, 1'b0);
`else
    check_out("snz_ignored", 1'b1, 2'b11, 1'b1);
    press_stop();
`endif
    tick_at(6'd0, 6'd3, 6'd0);
`ifdef BEEP_SNOOZE_EN
    check_out("snz_rering", 1'b1, 2'b11, 1'b1);
`else
    check_out("snz_rering", 1'b0, 2'b00, 1'b0);
`endif
    press_stop();
    check_out("snz_stop", 1'b0, 2'b00, 1'b0);
    tick_at(6'd0, 6'd3, 6'd0);
    check_out("snz_disarmed", 1'b0, 2'b00, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
